// File: rtl/kuznechik_enc_core.sv
// Kuznechik (GOST R 34.12-2015) iterative block encryption core.
// One block in flight. Each round does X (key add), then S (byte substitution),
// then L (linear layer). L runs in a 16-step pipeline that is local to this core.
module kuznechik_enc_core #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_block,
  input  logic [1279:0] round_keys,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_block,
  output logic          busy,
  output logic [3:0]    round_idx
);

  localparam int unsigned BLK_W    = 128;
  localparam int unsigned MAX_KEYS = 10;
  localparam int unsigned L_STEPS  = 16;
  localparam logic [3:0]  LAST_IDX = 4'(NUM_ROUNDS - 2);
  localparam logic [3:0]  L_LOAD   = 4'(L_STEPS - 1);

  localparam logic [7:0] PI [256] = '{
    8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
    8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
    8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
    8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
    8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
    8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
    8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
    8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
    8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
    8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
    8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
    8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
    8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
    8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
    8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
    8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
  };

  // l() coefficients; byte i of this constant multiplies state byte a_i
  localparam logic [127:0] L_COEF = {
    8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
    8'd1,   8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
  };

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_OUT} state_t;

  state_t           state;
  logic [BLK_W-1:0] st;
  logic [BLK_W-1:0] key_arr [MAX_KEYS];
  logic [BLK_W-1:0] key_cur;
  logic [BLK_W-1:0] key_last;
  logic [BLK_W-1:0] s_out;
  logic             put;
  logic [BLK_W-1:0] l_data;
  logic [3:0]       l_cnt;
  logic             l_ready;

  // GF(2^8) multiply modulo x^8+x^7+x^6+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'hC3) : (x << 1);
    end
    return p;
  endfunction

  // Byte-wise substitution through PI
  function automatic logic [BLK_W-1:0] sub_bytes(input logic [BLK_W-1:0] a);
    logic [BLK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = PI[a[8*i +: 8]];
    return r;
  endfunction

  // One R step: l() of all bytes enters at a15, the rest shift down one byte
  function automatic logic [BLK_W-1:0] r_step(input logic [BLK_W-1:0] a);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 16; i++) acc = acc ^ gf_mul(a[8*i +: 8], L_COEF[8*i +: 8]);
    return {acc, a[BLK_W-1:8]};
  endfunction

  // Split the key bus: key_arr[n] holds K(n+1)
  always_comb begin
    for (int i = 0; i < MAX_KEYS; i++) key_arr[i] = round_keys[BLK_W*i +: BLK_W];
  end

  assign key_cur  = key_arr[round_idx];
  assign key_last = round_keys[BLK_W*NUM_ROUNDS-1 -: BLK_W];
  assign s_out    = sub_bytes(st ^ key_cur);
  assign put      = (state == ST_ISSUE);

  // funcL control: 15 steps remain after the load; ready pulses once when done
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l_cnt   <= 4'd0;
      l_ready <= 1'b0;
    end else if (put) begin
      l_cnt   <= L_LOAD;
      l_ready <= 1'b0;
    end else begin
      l_ready <= (l_cnt == 4'd1);
      if (l_cnt != 4'd0) l_cnt <= l_cnt - 4'd1;
    end
  end

  // funcL datapath: first R on load, one more R per cycle while counting
  always_ff @(posedge clk) begin
    if (put) l_data <= r_step(s_out);
    else if (l_cnt != 4'd0) l_data <= r_step(l_data);
  end

  // Round controller and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      st        <= '0;
      round_idx <= 4'd0;
      out_block <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            st        <= in_block;
            round_idx <= 4'd0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (l_ready) begin
            if (round_idx < LAST_IDX) begin
              st        <= l_data;
              round_idx <= round_idx + 4'd1;
              state     <= ST_ISSUE;
            end else begin
              out_block <= l_data ^ key_last;
              out_valid <= 1'b1;
              state     <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            round_idx <= 4'd0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
